// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and mode encodings for the LED breathing driver
package led_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_OFF     = 2'd2;
  localparam logic [1:0] MODE_ON      = 2'd3;

endpackage

// File: rtl/led_breathe_driver_tick_gen.sv
// rtl/led_breathe_driver_tick_gen.sv - prescaler emitting one tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 48828
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign tick   = en & w_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_breathe_driver.sv
// rtl/led_breathe_driver.sv - PWM breathing / chase engine for active-low board LEDs
module led_breathe_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 48828,
  parameter int HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick,
  output logic [PWM_BITS-1:0] level
);

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic                w_tick;
  state_t              r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_level, w_level_nxt;
  logic [HW-1:0]       r_hold, w_hold_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [PWM_BITS-1:0] r_pwm;
  // One extra duty bit lets "solid on" exceed every counter value.
  logic [NUM_LEDS-1:0][PWM_BITS:0] r_duty, w_duty_nxt;
  logic [NUM_LEDS-1:0] w_led_on;

  tick_gen #(.DIV(STEP_DIV)) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= UP;
      r_level <= '0;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_hold  <= w_hold_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold;
    w_idx_nxt   = r_idx;
    if (w_tick) begin
      case (r_state)
        UP: begin
          if (r_level >= LVL_MAX - 1'b1) begin
            w_level_nxt = LVL_MAX;
            w_state_nxt = HOLD_HI;
            w_hold_nxt  = '0;
          end else begin
            w_level_nxt = r_level + 1'b1;
          end
        end
        HOLD_HI: begin
          if (r_hold == HW'(HOLD_STEPS - 1)) w_state_nxt = DOWN;
          else w_hold_nxt = r_hold + 1'b1;
        end
        DOWN: begin
          if (r_level <= PWM_BITS'(1)) begin
            w_level_nxt = '0;
            w_state_nxt = HOLD_LO;
            w_hold_nxt  = '0;
          end else begin
            w_level_nxt = r_level - 1'b1;
          end
        end
        HOLD_LO: begin
          if (r_hold == HW'(HOLD_STEPS - 1)) begin
            w_state_nxt = UP;
            w_idx_nxt   = (r_idx == IW'(NUM_LEDS - 1)) ? '0 : r_idx + 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        default: w_state_nxt = UP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !en) r_pwm <= '0;
    else                r_pwm <= r_pwm + 1'b1;
  end

  always_comb begin
    w_duty_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode)
        MODE_BREATHE: w_duty_nxt[i] = {1'b0, r_level};
        MODE_CHASE:   w_duty_nxt[i] = (IW'(i) == r_idx) ? {1'b0, r_level} : '0;
        MODE_OFF:     w_duty_nxt[i] = '0;
        default:      w_duty_nxt[i] = {1'b1, {PWM_BITS{1'b0}}};
      endcase
    end
  end

  // Latching only on the last PWM count keeps every period glitch-free.
  always_ff @(posedge clk) begin
    if (!resetn)                       r_duty <= '0;
    else if (en && (r_pwm == LVL_MAX)) r_duty <= w_duty_nxt;
  end

  always_comb begin
    w_led_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_led_on[i] = ({1'b0, r_pwm} < r_duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !en) led <= '1;
    else                led <= ~w_led_on;
  end

  assign step_tick = w_tick;
  assign level     = r_level;

endmodule

// File: tb/tb_led_breathe_driver.sv
// tb/tb_led_breathe_driver.sv - scoreboard bench for led_breathe_driver with a ramp reference model
module tb_led_breathe_driver;

  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int HS   = 2;
  localparam int MAXL = (1 << PB) - 1;
  localparam int PER  = 2 * MAXL + 2 * HS;
  localparam int NCYC = 6000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [NL-1:0] led;
  logic          step_tick;
  logic [PB-1:0] level;

  always #5 clk = ~clk;

  led_breathe_driver #(
    .NUM_LEDS   (NL),
    .PWM_BITS   (PB),
    .STEP_DIV   (SD),
    .HOLD_STEPS (HS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .mode      (mode),
    .led       (led),
    .step_tick (step_tick),
    .level     (level)
  );

  typedef struct {
    logic [NL-1:0] led;
    logic [PB-1:0] level;
    logic          tick;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  int            m_pre = 0;
  int            m_pwm = 0;
  int            m_n = 0;
  int            m_duty[NL];
  logic [NL-1:0] m_led = '1;

  // Ramp position as a closed-form function of the number of step ticks taken.
  function automatic int ref_level(input int n);
    int p;
    p = n % PER;
    if (p <= MAXL) return p;
    if (p <= MAXL + HS) return MAXL;
    if (p <= 2 * MAXL + HS) return MAXL - (p - MAXL - HS);
    return 0;
  endfunction

  function automatic int ref_idx(input int n);
    return (n / PER) % NL;
  endfunction

  task automatic model_edge(input logic rn, input logic e, input logic [1:0] md);
    if (!rn) begin
      m_pre = 0; m_pwm = 0; m_n = 0; m_led = '1;
      for (int i = 0; i < NL; i++) m_duty[i] = 0;
    end else if (!e) begin
      m_pre = 0; m_pwm = 0; m_led = '1;
    end else begin
      for (int i = 0; i < NL; i++) m_led[i] = !(m_pwm < m_duty[i]);
      if (m_pwm == MAXL) begin
        for (int i = 0; i < NL; i++) begin
          case (md)
            2'd0: m_duty[i] = ref_level(m_n);
            2'd1: m_duty[i] = (i == ref_idx(m_n)) ? ref_level(m_n) : 0;
            2'd2: m_duty[i] = 0;
            default: m_duty[i] = MAXL + 1;
          endcase
        end
      end
      if (m_pre == SD - 1) m_n++;
      m_pre = (m_pre + 1) % SD;
      m_pwm = (m_pwm + 1) % (MAXL + 1);
    end
  endtask

  initial begin
    exp_t e;
    int   seg_left = 0;
    int   off_left = 0;
    logic [1:0] seg_mode = 2'd0;
    for (int i = 0; i < NL; i++) m_duty[i] = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge(resetn, en, mode);
      #1;
      if (cyc < 2) begin
        resetn = 1'b0; en = 1'b1; mode = 2'd0;
      end else if (cyc < 400) begin
        resetn = 1'b1; en = 1'b1; mode = 2'd0;
      end else if (cyc < 1000) begin
        en = 1'b1; mode = 2'd1;
      end else if (cyc < 1100) begin
        mode = 2'd3;
      end else if (cyc < 1200) begin
        mode = 2'd2;
      end else begin
        if (seg_left == 0) begin
          seg_mode = 2'($urandom_range(0, 3));
          seg_left = $urandom_range(20, 160);
        end
        seg_left--;
        mode = seg_mode;
        if (off_left > 0) begin
          off_left--;
          en = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          off_left = $urandom_range(1, 25);
          en = 1'b0;
        end else begin
          en = 1'b1;
        end
        resetn = ($urandom_range(0, 399) != 0);
      end
      e.led   = m_led;
      e.level = PB'(ref_level(m_n));
      e.tick  = en && (m_pre == SD - 1);
      sb_q.push_back(e);
    end
    stim_done = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (led !== e.led) begin
        errors++;
        $display("FAIL led at %0t: got %b expected %b", $time, led, e.led);
      end
      checks++;
      if (level !== e.level) begin
        errors++;
        $display("FAIL level at %0t: got %0d expected %0d", $time, level, e.level);
      end
      checks++;
      if (step_tick !== e.tick) begin
        errors++;
        $display("FAIL step_tick at %0t: got %b expected %b", $time, step_tick, e.tick);
      end
    end
  end

  initial begin
    wait (stim_done);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
